// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian UART byte stream into instruction RAM words.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int WIDTH          = 16,
    parameter int IRAM_ADDR_BITS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    output logic [IRAM_ADDR_BITS-1:0] iram_wa,
    output logic                      iram_wen,
    output logic [WIDTH-1:0]          iram_din,
    output logic                      cpu_hold,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [IRAM_ADDR_BITS:0]   words_loaded
);
    localparam int MAX_WORDS = 2**IRAM_ADDR_BITS;

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK,
`endif
        FIN
    } state_t;

    state_t      state;
    logic [7:0]  len_hi;
    logic [7:0]  hi;
    logic [15:0] len;
    logic        last;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    // words_loaded doubles as the word counter; one extra bit keeps a full-RAM load from wrapping
    always_comb last = int'(words_loaded) + 1 == int'(len);

    // Loader FSM with registered RAM-port and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            len_hi       <= '0;
            hi           <= '0;
            len          <= '0;
            iram_wa      <= '0;
            iram_wen     <= 1'b0;
            iram_din     <= '0;
            cpu_hold     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            iram_wen <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state        <= LEN_HI;
                    busy         <= 1'b1;
                    cpu_hold     <= 1'b1;
                    done         <= 1'b0;
                    err          <= 1'b0;
                    words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum         <= '0;
`endif
                end
                LEN_HI: if (rx_valid) begin
                    len_hi <= rx_data;
                    state  <= LEN_LO;
                end
                LEN_LO: if (rx_valid) begin
                    len <= {len_hi, rx_data};
                    if ({len_hi, rx_data} == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state    <= CHK;
`else
                        state    <= FIN;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
`endif
                    end else if (int'({len_hi, rx_data}) > MAX_WORDS) begin
                        state    <= IDLE;
                        err      <= 1'b1;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                    end else begin
                        state <= DATA_HI;
                    end
                end
                DATA_HI: if (rx_valid) begin
                    hi    <= rx_data;
                    state <= DATA_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum  <= csum ^ rx_data;
`endif
                end
                DATA_LO: if (rx_valid) begin
                    iram_wen     <= 1'b1;
                    iram_din     <= {hi, rx_data};
                    iram_wa      <= words_loaded[IRAM_ADDR_BITS-1:0];
                    words_loaded <= words_loaded + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum         <= csum ^ rx_data;
                    state        <= last ? CHK : DATA_HI;
`else
                    state        <= last ? FIN : DATA_HI;
                    if (last) begin
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                    end
`endif
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: if (rx_valid) begin
                    state    <= FIN;
                    done     <= rx_data == csum;
                    err      <= rx_data != csum;
                    busy     <= 1'b0;
                    cpu_hold <= 1'b0;
                end
`endif
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for imem_loader.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        reset, start, rx_valid;
    logic [7:0]  rx_data;
    logic [7:0]  iram_wa;
    logic        iram_wen;
    logic [15:0] iram_din;
    logic        cpu_hold, busy, done, err;
    logic [8:0]  words_loaded;

    imem_loader dut (
        .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .iram_wa(iram_wa), .iram_wen(iram_wen), .iram_din(iram_din), .cpu_hold(cpu_hold),
        .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  wa;
        logic [15:0] din;
        int          cyc;
    } wr_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    wr_t        exp_q[$];
    logic [7:0] strm[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every write strobe must match the oldest expected write, including its cycle
    always @(negedge clk) begin
        wr_t e;
        if (iram_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write wa %0h din %0h", iram_wa, iram_din);
            end else begin
                e = exp_q.pop_front();
                chk("write_wa", iram_wa, e.wa);
                chk("write_din", iram_din, e.din);
                chk("write_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic make_stream(input int n);
        strm.delete();
        strm.push_back(8'(n >> 8));
        strm.push_back(8'(n));
        for (int i = 0; i < 2 * n; i++) strm.push_back(8'($urandom));
    endtask

    // reference: length from the first two bytes, word i = {byte 2+2i, byte 3+2i} at address i
    task automatic run_load(input int max_gap, input bit inj_start, input bit bad_ck);
        int         n, nw, t;
        bit         ee, ed;
        logic [7:0] ck;
        wr_t        w;
        n  = int'({strm[0], strm[1]});
        ee = n > 256;
        ed = !ee;
        nw = ee ? 0 : n;
        ck = 8'h00;
        for (int i = 2; i < strm.size(); i++) ck ^= strm[i];
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_hold", cpu_hold, 1);
        chk("start_done_clr", done, 0);
        chk("start_err_clr", err, 0);
        chk("start_words_clr", words_loaded, 0);
        for (int i = 0; i < strm.size(); i++) begin
            if (i >= 3 && i % 2 == 1) begin
                w.wa  = 8'((i - 3) / 2);
                w.din = {strm[i-1], strm[i]};
                w.cyc = cyc + 1;
                exp_q.push_back(w);
            end
            send(strm[i]);
            if (inj_start && i == 3) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            repeat ($urandom_range(max_gap)) tick();
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (!ee) begin
            send(bad_ck ? ~ck : ck);
            ed = !bad_ck;
            ee = bad_ck;
        end
`else
        if (bad_ck) ck = ~ck;
`endif
        t = 0;
        while (!(done | err) && t < 20) begin
            tick();
            t++;
        end
        chk("end_done", done, ed);
        chk("end_err", err, ee);
        chk("end_words", words_loaded, nw);
        chk("end_busy", busy, 0);
        chk("end_hold", cpu_hold, 0);
        tick();
        tick();
        chk("writes_drained", exp_q.size(), 0);
        chk("idle_done_held", done, ed);
    endtask

    initial begin
        wr_t w;
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tick();
        tick();
        chk("rst_wa", iram_wa, 0);
        chk("rst_wen", iram_wen, 0);
        chk("rst_din", iram_din, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_words", words_loaded, 0);
        reset = 1'b0;
        tick();
        send(8'hAB);
        tick();
        chk("idle_rx_busy", busy, 0);
        chk("idle_rx_words", words_loaded, 0);

        strm = '{8'h00, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        run_load(1, 1'b0, 1'b0);
        strm = '{8'h00, 8'h02, 8'hAA, 8'h55, 8'h0F, 8'hF0};
        run_load(0, 1'b0, 1'b0);
        strm = '{8'h01, 8'h01};
        run_load(0, 1'b0, 1'b0);
        strm = '{8'h00, 8'h00};
        run_load(0, 1'b0, 1'b0);

        start = 1'b1;
        tick();
        start = 1'b0;
        send(8'h00);
        send(8'h02);
        send(8'hAA);
        w.wa  = 8'h00;
        w.din = 16'hAA55;
        w.cyc = cyc + 1;
        exp_q.push_back(w);
        send(8'h55);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_hold", cpu_hold, 0);
        chk("midrst_words", words_loaded, 0);
        chk("midrst_drained", exp_q.size(), 0);
        make_stream(4);
        run_load(1, 1'b0, 1'b0);

        make_stream(3);
        run_load(1, 1'b1, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        make_stream(2);
        run_load(0, 1'b0, 1'b1);
`endif
        repeat (6) begin
            make_stream($urandom_range(6, 1));
            run_load(2, 1'b0, 1'b0);
        end
        make_stream(256);
        run_load(0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader directly upstream of the microcontroller's instruction RAM write port (write address, write enable, write data).
- Receives a byte stream from a UART receiver and assembles big-endian 16-bit instruction words.
- Writes the words to consecutive instruction RAM addresses starting at 0.
- Holds the processor (PC enable low) while a load is in progress.

Parameters:
WIDTH, 16, instruction word width; fixed at 2 bytes per word.
IRAM_ADDR_BITS, 8, instruction RAM address width; capacity 2**IRAM_ADDR_BITS words.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse (debounced button); begins a load
rx_valid  input  1  one-cycle strobe: rx_data holds a received byte
rx_data  input  8  received byte
iram_wa  output  IRAM_ADDR_BITS  instruction RAM write address
iram_wen  output  1  instruction RAM write enable, one-cycle pulse per word
iram_din  output  WIDTH  instruction RAM write data
cpu_hold  output  1  high while loading; the top level ANDs its inverse into PCenable and ORs it into the processor reset
busy  output  1  FSM not in IDLE
done  output  1  last load completed without error; held until next accepted start or reset
err  output  1  last load failed; held until next accepted start or reset
words_loaded  output  IRAM_ADDR_BITS+1  words written in the current/last load

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, word counter 0.
- Reset is sampled only on a clk edge and overrides every other input in that cycle.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK (CHK exists only with the optional feature), FIN.
- IDLE:
  - start=1: clear done, err and words_loaded; go to LEN_HI. busy and cpu_hold are 1 from the next cycle.
  - rx_valid in IDLE is ignored.
- LEN_HI / LEN_LO: on each rx_valid, capture the high byte, then the low byte, of the 16-bit word count N.
- On LEN_LO capture:
  - N = 0: go to FIN (done=1, no writes).
  - N > 2**IRAM_ADDR_BITS: err=1, go to IDLE, no writes.
  - Otherwise go to DATA_HI.
- DATA_HI: on rx_valid, latch the high byte.
- DATA_LO: on rx_valid, latch the low byte. In the next cycle:
  - iram_wen=1, iram_din={hi,lo}, iram_wa = word index.
  - words_loaded increments in that same cycle.
  - Write latency is 1 cycle after the rx_valid of the low byte.
- iram_wa and iram_din hold their last values when iram_wen=0.
- After the N-th write, go to CHK if the feature is enabled, otherwise to FIN.
- rx_valid on consecutive cycles must be accepted; no byte may be dropped at any rate of up to one byte per cycle.
- FIN: done=1 (err=1 on checksum failure), busy and cpu_hold fall; go to IDLE one cycle later. done/err persist in IDLE.
- start while busy is ignored and does not restart the load.
- Reset mid-load: immediate return to IDLE with all outputs 0. RAM words already written stay written.
- Address wrap: with N = 2**IRAM_ADDR_BITS the last write goes to address all-ones. The internal counter is IRAM_ADDR_BITS+1 bits wide, so it does not wrap before the terminal count compare.
- No timeout: a stalled stream keeps the FSM waiting indefinitely. The only exits are completion or reset.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the N data words, one extra byte is received in CHK.
  - It must equal the XOR of all 2N data bytes (length bytes excluded).
  - Match: done=1. Mismatch: err=1, done=0.
  - With N=0 the expected checksum is 0x00 and CHK is still entered.
- Not defined: CHK is absent; FIN follows the last write (or follows N=0) directly; err is raised only by an oversize N.

Test Plan:
- Reset, idle: hold reset 2 cycles -> every output 0. Then rx_valid with 0xAB in IDLE, no start -> no iram_wen, busy stays 0.
- Basic load: start, then bytes 00 03 12 34 56 78 9A BC -> iram_wen pulses at wa 0,1,2 with din 0x1234, 0x5678, 0x9ABC. Each pulse comes 1 cycle after its low byte. words_loaded=3; done=1; cpu_hold 0 after FIN. Feature enabled: append checksum byte 0x12^0x34^0x56^0x78^0x9A^0xBC (computed XOR) before done.
- Back-to-back bytes: rx_valid high for 6 consecutive cycles, stream 00 02 AA 55 0F F0 -> both words written correctly (0xAA55 @0, 0x0FF0 @1); no byte lost.
- Oversize and empty counts: length 01 01 (257) with IRAM_ADDR_BITS=8 -> err=1, no iram_wen, busy 0. Length 00 00 -> done=1 with zero writes (feature on: after checksum byte 00).
- Reset mid-load: reset asserted after the 2nd data byte -> next cycle busy=0, cpu_hold=0, words_loaded=0. A following start plus a full stream loads correctly.
- Start while busy: start pulse during DATA_HI -> ignored; the load completes with the original N. Feature on: wrong checksum byte -> err=1, done=0.
